aes_inv_key_sched: RTL and testbench



---
 rtl/aes_pkg.sv | 45 ++++
 rtl/aes_sbox.sv | 29 ++
 rtl/aes_inv_key_sched.sv | 119 +++++++++++
 tb/tb_aes_inv_key_sched.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types, round constants and word-level helpers for the AES key schedule.
package aes_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column of InvMixColumns: coefficients 0e/0b/0d/09 built from doublings.
  function automatic logic [31:0] inv_mix_column_word(input logic [31:0] w);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = w[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] val,
  output logic [7:0] sub_val
);

  // Byte 0 of the table sits in the most significant position.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign sub_val = SBOX[(11'd2047 - {val, 3'b000}) -: 8];

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key schedule: loaded with round key 10, streams keys 10..0.
// Optional INV_MIXCOL_KEY_EN presents rounds 1..9 in equivalent-inverse-cipher form.
module aes_inv_key_sched
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] last_key,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done,
  output logic [127:0] cipher_key
);

  state_t       state_reg;
  logic [127:0] key_reg;
  logic [127:0] key_next;
  logic [127:0] cipher_key_reg;
  logic [3:0]   round_reg;
  logic         rk_valid_reg;
  logic         busy_reg;
  logic         done_reg;
  logic         xfer;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] rot_p3;
  logic [31:0] sub_word;
  logic [7:0]  rcon_byte;

  assign xfer = rk_valid_reg & rk_ready;

  // Undo one forward expansion step: the last three words fall out as XORs of
  // neighbours, the first needs SubWord(RotWord) of the recovered last word.
  assign {w0, w1, w2, w3} = key_reg;
  assign p3     = w3 ^ w2;
  assign p2     = w2 ^ w1;
  assign p1     = w1 ^ w0;
  assign rot_p3 = rot_word(p3);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      aes_sbox u_sbox (
        .val     (rot_p3[8*gi +: 8]),
        .sub_val (sub_word[8*gi +: 8])
      );
    end
  endgenerate

  assign rcon_byte = (round_reg >= 4'd1 && round_reg <= 4'd10) ? RCON[round_reg] : 8'h00;
  assign p0        = w0 ^ sub_word ^ {rcon_byte, 24'h0};
  assign key_next  = {p0, p1, p2, p3};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      key_reg        <= '0;
      cipher_key_reg <= '0;
      round_reg      <= '0;
      rk_valid_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            key_reg      <= last_key;
            round_reg    <= 4'(NUM_ROUNDS);
            rk_valid_reg <= 1'b1;
            busy_reg     <= 1'b1;
            state_reg    <= STREAM;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (round_reg != 4'd0) begin
              key_reg   <= key_next;
              round_reg <= round_reg - 4'd1;
            end else begin
              // Round-0 key is the cipher key; rk_out keeps showing it.
              cipher_key_reg <= key_reg;
              done_reg       <= 1'b1;
              rk_valid_reg   <= 1'b0;
              busy_reg       <= 1'b0;
              state_reg      <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef INV_MIXCOL_KEY_EN
  always_comb begin
    rk_out = key_reg;
    if (round_reg != 4'd0 && round_reg != 4'(NUM_ROUNDS)) begin
      rk_out = {inv_mix_column_word(w0), inv_mix_column_word(w1),
                inv_mix_column_word(w2), inv_mix_column_word(w3)};
    end
  end
`else
  assign rk_out = key_reg;
`endif

  assign rk_round   = round_reg;
  assign rk_valid   = rk_valid_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign cipher_key = cipher_key_reg;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench: expected keys come from a forward AES-128 expansion model.
module tb_aes_inv_key_sched;

  localparam logic [127:0] CK_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] LK_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK9_FIPS = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] LK_ZERO = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [127:0] last_key;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;
  logic         done;
  logic [127:0] cipher_key;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] model_rk [11];

  aes_inv_key_sched #(.NUM_ROUNDS(10)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .last_key   (last_key),
    .rk_out     (rk_out),
    .rk_round   (rk_round),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .busy       (busy),
    .done       (done),
    .cipher_key (cipher_key)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] ck);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = ck[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] imc_model(input logic [127:0] k);
    logic [127:0] r;
    logic [7:0]   a [4];
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = k[127-32*c-8*j -: 8];
      for (int j = 0; j < 4; j++) begin
        acc = 8'h00;
        for (int m = 0; m < 4; m++) acc = acc ^ gmul(a[m], coef[(m - j + 4) % 4]);
        r[127-32*c-8*j -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] exp_out(input int r, input logic [127:0] k);
`ifdef INV_MIXCOL_KEY_EN
    if (r >= 1 && r <= 9) return imc_model(k);
`endif
    return k;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Caller is just past a negedge; ends at the negedge where done is visible.
  task automatic run_stream(input string tag, input logic [127:0] lk, input logic [127:0] ck,
                            input bit rand_ready, input bit start_mid, input bit start_last);
    int exp_r, n_xfer, cyc, low_run;
    bit first;
    expand_key(ck);
    start = 1'b1; last_key = lk; rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; last_key = rand128();
    exp_r = 10; n_xfer = 0; cyc = 0; low_run = 0; first = 1'b1;
    while (n_xfer < 11 && cyc < 500) begin
      n_cmp++;
      if (rk_valid !== 1'b1 || busy !== 1'b1 || rk_round !== 4'(exp_r) ||
          rk_out !== exp_out(exp_r, model_rk[exp_r])) begin
        n_fail++;
        $display("FAIL %s_key: got valid=%b busy=%b round=%0d rk_out=%h, expected valid=1 busy=1 round=%0d rk_out=%h",
                 tag, rk_valid, busy, rk_round, rk_out, exp_r, exp_out(exp_r, model_rk[exp_r]));
      end
      if (first) begin
        n_cmp++;
        if (done !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_done_width: got done=%b expected 0", tag, done);
        end
        first = 1'b0;
      end
      start = 1'b0;
      if ((start_mid && exp_r == 5) || (start_last && exp_r == 0)) begin
        start = 1'b1; last_key = rand128();
      end
      if (rand_ready) begin
        if (low_run > 0) begin
          rk_ready = 1'b0; low_run--;
        end else begin
          case ($urandom_range(0, 3))
            0: begin rk_ready = 1'b0; low_run = 4; end
            1: rk_ready = 1'b0;
            default: rk_ready = 1'b1;
          endcase
        end
      end else begin
        rk_ready = 1'b1;
      end
      if (rk_ready) begin
        n_xfer++;
        if (exp_r > 0) exp_r--;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    rk_ready = 1'($urandom_range(0, 1));
    n_cmp++;
    if (cyc >= 500 || done !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0 ||
        cipher_key !== ck || rk_out !== ck || rk_round !== 4'd0) begin
      n_fail++;
      $display("FAIL %s_end: got done=%b busy=%b valid=%b round=%0d cipher_key=%h rk_out=%h, expected done=1 busy=0 valid=0 round=0 cipher_key=%h",
               tag, done, busy, rk_valid, rk_round, cipher_key, rk_out, ck);
    end
    $display("stream %s: %0d cycles, cipher_key=%h", tag, cyc, cipher_key);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; rk_ready = 1'b1;
    last_key = CK_FIPS ^ rand128();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rk_out !== '0 || rk_round !== 4'd0 || rk_valid !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || cipher_key !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got rk_out=%h round=%0d valid=%b busy=%b done=%b cipher_key=%h, expected all 0",
               rk_out, rk_round, rk_valid, busy, done, cipher_key);
    end
    start = 1'b0; reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rk_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got valid=%b busy=%b expected 0 0", rk_valid, busy);
    end
    $display("reset: outputs cleared");
  endtask

  task automatic test_fips_vector();
    logic [127:0] s_out [13];
    logic [127:0] s_ck  [13];
    logic [3:0]   s_rnd [13];
    logic         s_done [13];
    logic         s_busy [13];
    start = 1'b1; last_key = LK_FIPS; rk_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      s_out[c] = rk_out; s_ck[c] = cipher_key; s_rnd[c] = rk_round;
      s_done[c] = done; s_busy[c] = busy;
    end
    n_cmp++;
    if (s_rnd[1] !== 4'd10 || s_out[1] !== LK_FIPS) begin
      n_fail++;
      $display("FAIL fips_cycle1: got round=%0d rk_out=%h expected round=10 rk_out=%h", s_rnd[1], s_out[1], LK_FIPS);
    end
    n_cmp++;
    if (s_rnd[2] !== 4'd9 || s_out[2] !== exp_out(9, RK9_FIPS)) begin
      n_fail++;
      $display("FAIL fips_cycle2: got round=%0d rk_out=%h expected round=9 rk_out=%h", s_rnd[2], s_out[2], exp_out(9, RK9_FIPS));
    end
    n_cmp++;
    if (s_rnd[11] !== 4'd0 || s_out[11] !== CK_FIPS) begin
      n_fail++;
      $display("FAIL fips_cycle11: got round=%0d rk_out=%h expected round=0 rk_out=%h", s_rnd[11], s_out[11], CK_FIPS);
    end
    n_cmp++;
    if (s_done[12] !== 1'b1 || s_busy[12] !== 1'b0 || s_ck[12] !== CK_FIPS || s_done[11] !== 1'b0) begin
      n_fail++;
      $display("FAIL fips_cycle12: got done=%b busy=%b cipher_key=%h (done at 11=%b) expected done=1 busy=0 cipher_key=%h",
               s_done[12], s_busy[12], s_ck[12], s_done[11], CK_FIPS);
    end
    $display("fips: 11 keys streamed, cipher_key=%h", s_ck[12]);
  endtask

  task automatic test_backpressure();
    run_stream("backpressure", LK_FIPS, CK_FIPS, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_start();
    @(negedge clk);
    run_stream("ignored_start", LK_FIPS, CK_FIPS, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    run_stream("start_at_last", LK_FIPS, CK_FIPS, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_at_last_ignored: got valid=%b busy=%b done=%b expected 0 0 0", rk_valid, busy, done);
    end
    run_stream("back_to_back_a", LK_ZERO, 128'h0, 1'b0, 1'b0, 1'b0);
    run_stream("back_to_back_b", LK_FIPS, CK_FIPS, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_midstream_reset();
    int cyc;
    @(negedge clk);
    start = 1'b1; last_key = LK_FIPS; rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (rk_round !== 4'd6 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (rk_round !== 4'd6) begin
      n_fail++;
      $display("FAIL midreset_reach6: got round=%0d expected 6", rk_round);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (rk_out !== '0 || rk_round !== 4'd0 || rk_valid !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || cipher_key !== '0) begin
      n_fail++;
      $display("FAIL midreset_clear: got rk_out=%h round=%0d valid=%b busy=%b done=%b cipher_key=%h, expected all 0",
               rk_out, rk_round, rk_valid, busy, done, cipher_key);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || rk_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_no_done: got done=%b valid=%b expected 0 0", done, rk_valid);
      end
    end
    reset_n = 1'b1;
    $display("midstream reset: outputs cleared at round 6");
    run_stream("after_reset", LK_FIPS, CK_FIPS, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_zero_key();
    @(negedge clk);
    run_stream("zero_key", LK_ZERO, 128'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random_keys();
    logic [127:0] ck;
    for (int i = 0; i < 4; i++) begin
      ck = rand128();
      expand_key(ck);
      @(negedge clk);
      run_stream($sformatf("random%0d", i), model_rk[10], ck, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; rk_ready = 1'b0; last_key = '0;
    build_sbox();
    test_reset();
    test_fips_vector();
    test_backpressure();
    test_ignored_start();
    test_back_to_back();
    test_midstream_reset();
    test_zero_key();
    test_random_keys();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
